vc_dest_arbiter: RTL and testbench
==================================

# vc_dest_arbiter

Stage between the virtual-channel FIFOs (VC0, VC1) and the destination FIFOs (D0, D1) of the PCIe QoS interconnect. Pops one word per cycle from VC0 or VC1 (VC0 has strict priority), inspects the destination bit and writes the word into D0 or D1. Popping is throttled by the flow-control FSM's active/pause indications, and a pipeline tracks words already in flight.

## Interface
- BW, 6, word width; bit BW-1 = destination (0→D0, 1→D1), bit BW-2 = VC class (pass-through)
- STARVE_LIM, 4, consecutive VC0 grants tolerated while VC1 waits (used only with starvation guard)
- clk  in  1  single clock, all flops on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- active  in  1  flow-control FSM in ACTIVE; pops allowed only when high
- D0_pause, D1_pause  in  1  destination almost-full (threshold set upstream, ≥2 entries headroom)
- VC0_empty, VC1_empty  in  1  source FIFO empty flags
- VC0_data_out, VC1_data_out  in  BW  source FIFO read data, valid the cycle after rd
- VC0_rd, VC1_rd  out  1  pop strobes (combinational from state and inputs)
- D0_wr, D1_wr  out  1  destination push strobes (registered)
- D0_data_in, D1_data_in  out  BW  destination write data (registered)
- starve_cnt_out  out  3  current starvation count (0 when guard compiled out)

## Operation
- Eligibility: can_pop = active & ~D0_pause & ~D1_pause (both pauses gate, since destination unknown before pop).
- Grant: VC0_rd = can_pop & ~VC0_empty & ~force1; VC1_rd = can_pop & ~VC1_empty & (VC0_empty | force1). Never both high; never pop an empty FIFO.
- Stage 1 (flops): pend_valid ← VC0_rd|VC1_rd; pend_vc ← VC1_rd.
- Stage 2 (flops): when pend_valid, word = pend_vc ? VC1_data_out : VC0_data_out; word[BW-1]=0 → D0_wr←1, D0_data_in←word; else D1_wr←1, D1_data_in←word. Strobe not taken is 0; unused data register holds its last value.
- FSM states: IDLE (nothing popped last cycle), RUN (pop issued last cycle), HOLD (can_pop low and a FIFO non-empty). IDLE→RUN on any pop; RUN→IDLE when both empty; any→HOLD when can_pop=0 and ~(VC0_empty&VC1_empty); HOLD→RUN when can_pop returns and a pop issues. State is observable only through strobes; it exists for debug and coverage.
- Deassertion of active or assertion of a pause stops new pops the same cycle; words already in stage 1/2 still complete (≤2 words after pause).
- Data is never altered; VC bit passes through.

## Timing
- Reset values: VC0_rd=VC1_rd=0, D0_wr=D1_wr=0, D0_data_in=D1_data_in=0, pend_valid=0, state=IDLE, starve_cnt=0.
- Latency: rd in cycle N → wr asserted in cycle N+2 with that word. Throughput 1 word/cycle sustained.
- Order preserved per VC; across VCs, order is grant order.
- Both VCs non-empty: VC0 wins every cycle (unless guard forces VC1).
- Pause asserted in cycle N: no rd in N; in-flight words from N-1, N-2 still written.
- Reset mid-operation: in-flight words are dropped, strobes low immediately (async).

## Configuration
- VC_STARVE_GUARD_EN defined: starve_cnt increments on each VC0 grant while VC1 non-empty, clears on VC1 grant or VC1 empty; when starve_cnt == STARVE_LIM, force1=1 for one grant (VC1 wins), then count clears. Saturates, never wraps.
- Not defined: force1 tied 0, strict VC0 priority, starve_cnt_out=0.

## Structure
- Shared package: BW default, DEST_BIT/VC_BIT index constants, FSM state enum (IDLE/RUN/HOLD).
- One sub-module: vc_dest_route (stage-2 demux register: pend_valid/pend_vc/data in → D0/D1 wr/data out).

## Test plan
- Reset, active=1, VC0 holds 6'b00_0101 → VC0_rd cycle 1, D0_wr with 6'b00_0101 in cycle 3; D1_wr stays 0.
- VC0={01_0111}, VC1={10_0110} both non-empty → VC0 popped first, D0 gets 01_0111, next cycle D1 gets 10_0110.
- Streaming 5 words, D1_pause raised in cycle 2 → no rd from cycle 2, exactly the 2 in-flight words written, resume on pause drop without loss or duplication.
- active=0 with non-empty FIFOs → no rd, no wr; state HOLD.
- With VC_STARVE_GUARD_EN, STARVE_LIM=4, both FIFOs full → grant pattern VC0×4, VC1×1, repeating; without macro → VC0 only until empty.
- Assert reset while 2 words in flight → all strobes 0 at once, data outputs 0, no write after release until new pop.

Source files
------------

// File: rtl/vc_dest_arbiter_pkg.sv
// Shared types and constants for the VC-to-destination arbiter slice.
// Word layout: [DEST_BIT] selects D0/D1, [VC_BIT] carries the VC class untouched.
package vc_dest_arbiter_pkg;

    localparam int unsigned BW         = 6;
    localparam int unsigned DEST_BIT   = BW - 1;
    localparam int unsigned VC_BIT     = BW - 2;
    localparam int unsigned STARVE_W   = 3;
    localparam int unsigned STARVE_LIM = 4;

    typedef logic [BW-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic word_dest(input word_t w);
        return w[DEST_BIT];
    endfunction

    function automatic logic word_vc(input word_t w);
        return w[VC_BIT];
    endfunction

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Bundle of source-FIFO, destination-FIFO and flow-control signals seen by the arbiter.
// master = arbiter side, slave = surrounding FIFOs / flow-control FSM.
interface vc_dest_arbiter_if;
    import vc_dest_arbiter_pkg::*;

    logic                active;
    logic                D0_pause;
    logic                D1_pause;
    logic                VC0_empty;
    logic                VC1_empty;
    word_t               VC0_data_out;
    word_t               VC1_data_out;
    logic                VC0_rd;
    logic                VC1_rd;
    logic                D0_wr;
    logic                D1_wr;
    word_t               D0_data_in;
    word_t               D1_data_in;
    logic [STARVE_W-1:0] starve_cnt_out;

    modport master (
        input  active, D0_pause, D1_pause, VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
        output VC0_rd, VC1_rd, D0_wr, D1_wr, D0_data_in, D1_data_in, starve_cnt_out
    );

    modport slave (
        output active, D0_pause, D1_pause, VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
        input  VC0_rd, VC1_rd, D0_wr, D1_wr, D0_data_in, D1_data_in, starve_cnt_out
    );

endinterface

// File: rtl/vc_dest_route.sv
// Stage-2 register: picks the popped word from the granted VC and pushes it to D0 or D1.
module vc_dest_route
    import vc_dest_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  pend_valid,
    input  logic  pend_vc,
    input  word_t vc0_data,
    input  word_t vc1_data,
    output logic  d0_wr,
    output logic  d1_wr,
    output word_t d0_data,
    output word_t d1_data
);

    word_t word;

    assign word = pend_vc ? vc1_data : vc0_data;

    // Data registers of the destination not taken keep their previous value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_wr   <= 1'b0;
            d1_wr   <= 1'b0;
            d0_data <= '0;
            d1_data <= '0;
        end else begin
            d0_wr <= 1'b0;
            d1_wr <= 1'b0;
            if (pend_valid) begin
                if (word_dest(word)) begin
                    d1_wr   <= 1'b1;
                    d1_data <= word;
                end else begin
                    d0_wr   <= 1'b1;
                    d0_data <= word;
                end
            end
        end
    end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Pops VC0/VC1 (VC0 strict priority) into D0/D1 by destination bit, 2-cycle rd-to-wr latency.
// Optional VC_STARVE_GUARD_EN: after STARVE_LIM VC0 grants with VC1 waiting, VC1 gets one grant.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
(
    input logic               clk,
    input logic               reset,
    vc_dest_arbiter_if.master bus
);

    logic   can_pop;
    logic   force1;
    logic   pop;
    logic   both_empty;
    logic   pend_valid;
    logic   pend_vc;
    state_t state;
    state_t state_nxt;

    // Both pauses gate because the destination is unknown until the word is read.
    assign can_pop    = ~reset & bus.active & ~bus.D0_pause & ~bus.D1_pause;
    assign both_empty = bus.VC0_empty & bus.VC1_empty;
    assign pop        = bus.VC0_rd | bus.VC1_rd;

`ifdef VC_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_cnt;

    assign force1 = (starve_cnt == STARVE_W'(STARVE_LIM)) & ~bus.VC1_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bus.VC1_rd || bus.VC1_empty) begin
            starve_cnt <= '0;
        end else if (bus.VC0_rd && (starve_cnt != STARVE_W'(STARVE_LIM))) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign bus.starve_cnt_out = starve_cnt;
`else
    assign force1             = 1'b0;
    assign bus.starve_cnt_out = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Debug/coverage FSM; it never feeds the data path.
    always_comb begin
        state_nxt = state;
        if (!can_pop && !both_empty) begin
            state_nxt = HOLD;
        end else begin
            case (state)
                IDLE:    if (pop) state_nxt = RUN;
                RUN:     if (both_empty) state_nxt = IDLE;
                HOLD: begin
                    if (pop)             state_nxt = RUN;
                    else if (both_empty) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.VC0_rd = 1'b0;
        bus.VC1_rd = 1'b0;
        if (can_pop) begin
            bus.VC0_rd = ~bus.VC0_empty & ~force1;
            bus.VC1_rd = ~bus.VC1_empty & (bus.VC0_empty | force1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_vc    <= 1'b0;
        end else begin
            pend_valid <= pop;
            pend_vc    <= bus.VC1_rd;
        end
    end

    vc_dest_route u_route (
        .clk        (clk),
        .reset      (reset),
        .pend_valid (pend_valid),
        .pend_vc    (pend_vc),
        .vc0_data   (bus.VC0_data_out),
        .vc1_data   (bus.VC1_data_out),
        .d0_wr      (bus.D0_wr),
        .d1_wr      (bus.D1_wr),
        .d0_data    (bus.D0_data_in),
        .d1_data    (bus.D1_data_in)
    );

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: behavioural source FIFOs, write/grant logs, fixed expectations.
module tb_vc_dest_arbiter;
    import vc_dest_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vc_dest_arbiter_if bus();

    vc_dest_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Source FIFO models: read data appears the cycle after rd.
    word_t vc0_mem [32];
    word_t vc1_mem [32];
    int    vc0_wp = 0, vc0_rp = 0, vc1_wp = 0, vc1_rp = 0;

    assign bus.VC0_empty = (vc0_rp == vc0_wp);
    assign bus.VC1_empty = (vc1_rp == vc1_wp);

    always @(posedge clk) begin
        if (bus.VC0_rd) begin
            bus.VC0_data_out <= vc0_mem[vc0_rp[4:0]];
            vc0_rp           <= vc0_rp + 1;
        end
        if (bus.VC1_rd) begin
            bus.VC1_data_out <= vc1_mem[vc1_rp[4:0]];
            vc1_rp           <= vc1_rp + 1;
        end
    end

    int    cyc = 0;
    int    grant_q [$];
    int    g_cyc [$];
    word_t d0_q [$];
    word_t d1_q [$];
    int    d0_cyc [$];
    int    d1_cyc [$];
    int    max_starve = 0;
    int    both_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.VC0_rd) begin grant_q.push_back(0); g_cyc.push_back(cyc); end
        if (bus.VC1_rd) begin grant_q.push_back(1); g_cyc.push_back(cyc); end
        if (bus.VC0_rd && bus.VC1_rd) both_rd = both_rd + 1;
        if (bus.D0_wr) begin d0_q.push_back(bus.D0_data_in); d0_cyc.push_back(cyc); end
        if (bus.D1_wr) begin d1_q.push_back(bus.D1_data_in); d1_cyc.push_back(cyc); end
        if (int'(bus.starve_cnt_out) > max_starve) max_starve = int'(bus.starve_cnt_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        grant_q.delete();
        g_cyc.delete();
        d0_q.delete();
        d1_q.delete();
        d0_cyc.delete();
        d1_cyc.delete();
        max_starve = 0;
    endtask

    task automatic push0(input word_t w);
        vc0_mem[vc0_wp[4:0]] = w;
        vc0_wp = vc0_wp + 1;
    endtask

    task automatic push1(input word_t w);
        vc1_mem[vc1_wp[4:0]] = w;
        vc1_wp = vc1_wp + 1;
    endtask

    int exp_g [12];

    initial begin
        reset        = 1'b1;
        bus.active   = 1'b1;
        bus.D0_pause = 1'b0;
        bus.D1_pause = 1'b0;

        // Reset state, single VC0 word to D0 with 2-cycle latency
        push0(6'b000101);
        tick(2);
        check("rst_vc0_rd", 32'(bus.VC0_rd), 32'd0);
        check("rst_d0_wr", 32'(bus.D0_wr), 32'd0);
        check("rst_d1_wr", 32'(bus.D1_wr), 32'd0);
        check("rst_d0_data", 32'(bus.D0_data_in), 32'd0);
        check("rst_d1_data", 32'(bus.D1_data_in), 32'd0);
        check("rst_starve", 32'(bus.starve_cnt_out), 32'd0);
        clear_logs();
        reset = 1'b0;
        tick(6);
        check("t1_grants", 32'(grant_q.size()), 32'd1);
        check("t1_grant_vc", 32'(grant_q[0]), 32'd0);
        check("t1_d0_cnt", 32'(d0_q.size()), 32'd1);
        check("t1_d0_data", 32'(d0_q[0]), 32'h05);
        check("t1_latency", 32'(d0_cyc[0] - g_cyc[0]), 32'd2);
        check("t1_d1_cnt", 32'(d1_q.size()), 32'd0);

        // Both VCs hold one word: VC0 first, then VC1, on consecutive cycles
        clear_logs();
        push0(6'b010111);
        push1(6'b100110);
        tick(6);
        check("t2_grants", 32'(grant_q.size()), 32'd2);
        check("t2_first", 32'(grant_q[0]), 32'd0);
        check("t2_second", 32'(grant_q[1]), 32'd1);
        check("t2_d0_data", 32'(d0_q[0]), 32'h17);
        check("t2_d1_data", 32'(d1_q[0]), 32'h26);
        check("t2_order", 32'(d1_cyc[0] - d0_cyc[0]), 32'd1);

        // Stream 5 words, D1_pause in cycle 2: only 2 in-flight words land, then resume
        bus.active = 1'b0;
        clear_logs();
        push0(6'b000001);
        push0(6'b100010);
        push0(6'b000011);
        push0(6'b110100);
        push0(6'b000101);
        tick(1);
        bus.active = 1'b1;
        tick(2);
        bus.D1_pause = 1'b1;
        tick(4);
        check("t3_pause_grants", 32'(grant_q.size()), 32'd2);
        check("t3_pause_writes", 32'(d0_q.size() + d1_q.size()), 32'd2);
        check("t3_pause_d0", 32'(d0_q[0]), 32'h01);
        check("t3_pause_d1", 32'(d1_q[0]), 32'h22);
        bus.D1_pause = 1'b0;
        tick(8);
        check("t3_grants", 32'(grant_q.size()), 32'd5);
        check("t3_d0_cnt", 32'(d0_q.size()), 32'd3);
        check("t3_d1_cnt", 32'(d1_q.size()), 32'd2);
        check("t3_d0_w1", 32'(d0_q[1]), 32'h03);
        check("t3_d0_w2", 32'(d0_q[2]), 32'h05);
        check("t3_d1_w1", 32'(d1_q[1]), 32'h34);

        // active low with data waiting: nothing moves, FSM parks in HOLD
        bus.active = 1'b0;
        clear_logs();
        push0(6'b001000);
        push1(6'b111000);
        tick(4);
        check("t4_grants", 32'(grant_q.size()), 32'd0);
        check("t4_writes", 32'(d0_q.size() + d1_q.size()), 32'd0);
        check("t4_state", 32'(dut.state), 32'(HOLD));
        bus.active = 1'b1;
        tick(6);
        check("t4_d0_data", 32'(d0_q[0]), 32'h08);
        check("t4_d1_data", 32'(d1_q[0]), 32'h38);
        check("t4_grant_order", 32'(grant_q[0] * 2 + grant_q[1]), 32'd1);

        // Both FIFOs loaded with 6 words each: grant pattern depends on the starvation guard
        bus.active = 1'b0;
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            push0(6'(i));
            push1(6'(6'b110000 | i));
        end
`ifdef VC_STARVE_GUARD_EN
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
`else
        exp_g = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
`endif
        tick(1);
        bus.active = 1'b1;
        tick(18);
        check("t5_grants", 32'(grant_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t5_grant%0d", i), 32'(grant_q[i]), 32'(exp_g[i]));
        end
        check("t5_d0_cnt", 32'(d0_q.size()), 32'd6);
        check("t5_d1_cnt", 32'(d1_q.size()), 32'd6);
`ifdef VC_STARVE_GUARD_EN
        check("t5_max_starve", 32'(max_starve), 32'd4);
`else
        check("t5_max_starve", 32'(max_starve), 32'd0);
`endif
        check("t5_starve_end", 32'(bus.starve_cnt_out), 32'd0);

        // Reset with 2 words in flight: strobes drop at once, in-flight words lost
        clear_logs();
        push0(6'b001010);
        push0(6'b001011);
        push0(6'b001100);
        push0(6'b001101);
        tick(2);
        reset      = 1'b1;
        bus.active = 1'b0;
        #1;
        check("t6_d0_wr", 32'(bus.D0_wr), 32'd0);
        check("t6_d1_wr", 32'(bus.D1_wr), 32'd0);
        check("t6_d0_data", 32'(bus.D0_data_in), 32'd0);
        check("t6_vc0_rd", 32'(bus.VC0_rd), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(4);
        check("t6_no_write", 32'(d0_q.size() + d1_q.size()), 32'd0);
        bus.active = 1'b1;
        tick(6);
        check("t6_d0_cnt", 32'(d0_q.size()), 32'd2);
        check("t6_d0_w0", 32'(d0_q[0]), 32'h0c);
        check("t6_d0_w1", 32'(d0_q[1]), 32'h0d);

        check("never_both_rd", 32'(both_rd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
